// File: rtl/movegen_scheduler.sv
// movegen_scheduler: walks squares 0..63 for the side to move, dispatches the
// piece-move generator once per own piece and turns its candidate targets into
// a flat (from, to) move stream with a saturating move count.
package movegen_pkg;
   typedef enum logic [2:0] {
      EMPTY  = 3'd0,
      PAWN   = 3'd1,
      KNIGHT = 3'd2,
      BISHOP = 3'd3,
      ROOK   = 3'd4,
      QUEEN  = 3'd5,
      KING   = 3'd6
   } piece_t;

   typedef enum logic {
      WHITE = 1'b0,
      BLACK = 1'b1
   } color_t;

   typedef struct packed {
      color_t color;
      piece_t piece;
   } fullpiece_t;
endpackage

module movegen_scheduler
   import movegen_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  color_t             side,
   input  fullpiece_t [63:0]  board,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [COUNT_W-1:0] move_count,
   output logic               move_valid,
   output logic [5:0]         move_from,
   output logic [5:0]         move_to,
   output logic               gen_req,
   output logic [5:0]         gen_from,
   output piece_t             gen_piece,
   input  logic               gen_ack,
   input  logic               gen_valid,
   input  logic [5:0]         gen_position
);

   localparam int TMO_W = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SCAN    = 3'd1,
      REQ     = 3'd2,
      RELEASE = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [5:0]         sq_q, sq_d;
   color_t             side_q, side_d;
   logic [5:0]         gen_from_q, gen_from_d;
   piece_t             gen_piece_q, gen_piece_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               error_q, error_d;
   logic [COUNT_W-1:0] move_count_q, move_count_d;
   logic               move_valid_q, move_valid_d;
   logic [5:0]         move_from_q, move_from_d;
   logic [5:0]         move_to_q, move_to_d;

   fullpiece_t cur_sq;
   logic       own_piece;
   logic       last_sq;
   logic       tmo_expired;

   assign cur_sq      = board[sq_q];
   assign own_piece   = (cur_sq.piece != EMPTY) && (cur_sq.color == side_q);
   assign last_sq     = (sq_q == 6'd63);
   // An ack in the final allowed cycle is honoured rather than treated as a timeout
   assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT - 1)) && !gen_ack;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: one square per SCAN cycle, 4-phase handshake in REQ/RELEASE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN: begin
            if (own_piece)    state_d = REQ;
            else if (last_sq) state_d = DONE;
         end
         REQ:     if (gen_ack || tmo_expired) state_d = RELEASE;
         RELEASE: if (!gen_ack) state_d = last_sq ? DONE : SCAN;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode: handshake and status strobes follow the state directly
   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      gen_req = 1'b0;
      case (state_q)
         SCAN, RELEASE: busy = 1'b1;
         REQ: begin
            busy    = 1'b1;
            gen_req = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Datapath next values: square walk, dispatch capture, move tagging, timeout
   always_comb begin
      sq_d         = sq_q;
      side_d       = side_q;
      gen_from_d   = gen_from_q;
      gen_piece_d  = gen_piece_q;
      tmo_d        = tmo_q;
      error_d      = error_q;
      move_count_d = move_count_q;
      move_valid_d = 1'b0;
      move_from_d  = move_from_q;
      move_to_d    = move_to_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               side_d       = side;
               sq_d         = 6'd0;
               move_count_d = '0;
               error_d      = 1'b0;
            end
         end
         SCAN: begin
            if (own_piece) begin
               gen_from_d  = sq_q;
               gen_piece_d = cur_sq.piece;
               tmo_d       = '0;
            end else if (!last_sq) begin
               sq_d = sq_q + 6'd1;
            end
         end
         REQ: begin
            if (gen_valid) begin
               move_valid_d = 1'b1;
               move_from_d  = gen_from_q;
               move_to_d    = gen_position;
               if (move_count_q != {COUNT_W{1'b1}}) begin
                  move_count_d = move_count_q + COUNT_W'(1);
               end
            end
            if (!gen_ack) begin
               if (tmo_expired) error_d = 1'b1;
               else             tmo_d   = tmo_q + TMO_W'(1);
            end
         end
         RELEASE: begin
            if (!gen_ack && !last_sq) sq_d = sq_q + 6'd1;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sq_q         <= 6'd0;
         side_q       <= WHITE;
         gen_from_q   <= 6'd0;
         gen_piece_q  <= EMPTY;
         tmo_q        <= '0;
         error_q      <= 1'b0;
         move_count_q <= '0;
         move_valid_q <= 1'b0;
         move_from_q  <= 6'd0;
         move_to_q    <= 6'd0;
      end else begin
         sq_q         <= sq_d;
         side_q       <= side_d;
         gen_from_q   <= gen_from_d;
         gen_piece_q  <= gen_piece_d;
         tmo_q        <= tmo_d;
         error_q      <= error_d;
         move_count_q <= move_count_d;
         move_valid_q <= move_valid_d;
         move_from_q  <= move_from_d;
         move_to_q    <= move_to_d;
      end
   end

   assign error      = error_q;
   assign move_count = move_count_q;
   assign move_valid = move_valid_q;
   assign move_from  = move_from_q;
   assign move_to    = move_to_q;
   assign gen_from   = gen_from_q;
   assign gen_piece  = gen_piece_q;

endmodule

// File: tb/tb_movegen_scheduler.sv
// tb_movegen_scheduler: drives full-board passes against a stub generator and
// compares the DUT with a square-list / move-list reference model.
module tb_movegen_scheduler;
   import movegen_pkg::*;

   localparam int TIMEOUT = 8;
   localparam int COUNT_W = 8;
   localparam int CNT_MAX = (1 << COUNT_W) - 1;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   color_t             side;
   fullpiece_t [63:0]  board;
   logic               busy, done, error, move_valid, gen_req;
   logic [COUNT_W-1:0] move_count;
   logic [5:0]         move_from, move_to, gen_from, gen_position;
   piece_t             gen_piece;
   logic               gen_ack, gen_valid;

   int checks = 0;
   int errors = 0;

   // Stub generator behaviour for the d-th dispatch of a pass:
   // ack on REQ cycle planAck (0 = never), keep ack planHold extra cycles,
   // gen_valid on REQ cycle i when planMask[i] is set, target planPos[i].
   int          planAck  [64];
   int          planHold [64];
   logic [15:0] planMask [64];
   logic [5:0]  planPos  [64][16];

   int          expDisp[$];
   logic [11:0] expMoves[$];
   int          expCount;
   logic        expErr;
   int          expLat;

   always #5 clk = ~clk;

   movegen_scheduler #(
      .TIMEOUT(TIMEOUT),
      .COUNT_W(COUNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .side(side),
      .board(board),
      .busy(busy),
      .done(done),
      .error(error),
      .move_count(move_count),
      .move_valid(move_valid),
      .move_from(move_from),
      .move_to(move_to),
      .gen_req(gen_req),
      .gen_from(gen_from),
      .gen_piece(gen_piece),
      .gen_ack(gen_ack),
      .gen_valid(gen_valid),
      .gen_position(gen_position)
   );

   // Single comparison point: counts the check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clearBoard();
      for (int s = 0; s < 64; s++) begin
         board[s].color = WHITE;
         board[s].piece = EMPTY;
      end
      for (int d = 0; d < 64; d++) begin
         planAck[d]  = 1;
         planHold[d] = 0;
         planMask[d] = 16'h0;
         for (int i = 0; i < 16; i++) planPos[d][i] = 6'($urandom);
      end
   endtask

   task automatic randPlan(input int d);
      planAck[d]  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      planHold[d] = int'($urandom_range(0, 2));
      planMask[d] = 16'($urandom);
      for (int i = 0; i < 16; i++) planPos[d][i] = 6'($urandom);
   endtask

   // Reference: own pieces in ascending square order; each contributes its
   // planned targets, REQ length (ack cycle or TIMEOUT) plus RELEASE length.
   function automatic void buildModel(input color_t s);
      int total;
      int k;
      expDisp.delete();
      expMoves.delete();
      total  = 0;
      expErr = 1'b0;
      expLat = 65;
      for (int sq = 0; sq < 64; sq++) begin
         if (board[sq].piece != EMPTY && board[sq].color == s) expDisp.push_back(sq);
      end
      foreach (expDisp[d]) begin
         k = (planAck[d] != 0) ? planAck[d] : TIMEOUT;
         if (planAck[d] == 0) expErr = 1'b1;
         for (int i = 1; i <= k; i++) begin
            if (planMask[d][i]) begin
               expMoves.push_back({6'(expDisp[d]), planPos[d][i]});
               total++;
            end
         end
         expLat += k + 1 + ((planAck[d] != 0) ? planHold[d] : 0);
      end
      expCount = (total > CNT_MAX) ? CNT_MAX : total;
   endfunction

   // One full pass: start pulse, stub generator, move monitor, end-of-pass checks.
   // resetAt >= 0 asserts reset at the first REQ cycle of that dispatch.
   task automatic applyStimulus(input color_t s, input int resetAt);
      int          n, d, i, dd, holdLeft, phase, running, doneAt, busyBad, expFrom;
      logic [11:0] mv;
      buildModel(s);
      @(negedge clk);
      side  = s;
      start = 1'b1;
      n = 0; d = 0; i = 0; holdLeft = 0; phase = 0; running = 0; doneAt = -1; busyBad = 0;
      while (doneAt < 0 && n < 3000) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (move_valid) begin
            checkOutput("move pending", 32'(expMoves.size() > 0), 32'd1);
            running = (running < CNT_MAX) ? running + 1 : CNT_MAX;
            if (expMoves.size() > 0) begin
               mv = expMoves.pop_front();
               checkOutput("move from/to", 32'({move_from, move_to}), 32'(mv));
            end
            checkOutput("running count", 32'(move_count), 32'(running));
         end
         dd      = (d < 64) ? d : 63;
         expFrom = (d < expDisp.size()) ? expDisp[d] : -1;
         if (phase == 0) begin
            gen_valid = 1'b0;
            gen_ack   = 1'b0;
            if (gen_req) begin
               if (d == resetAt) begin
                  reset = 1'b1;
                  @(negedge clk);
                  checkOutput("reset gen_req", 32'(gen_req), 32'd0);
                  checkOutput("reset busy", 32'(busy), 32'd0);
                  checkOutput("reset count", 32'(move_count), 32'd0);
                  checkOutput("reset done", 32'(done), 32'd0);
                  reset = 1'b0;
                  @(negedge clk);
                  checkOutput("idle after reset", 32'({busy, done, gen_req}), 32'd0);
                  return;
               end
               checkOutput("dispatch expected", 32'(d < expDisp.size()), 32'd1);
               checkOutput("gen_from", 32'(gen_from), 32'(expFrom));
               if (expFrom >= 0) checkOutput("gen_piece", 32'(gen_piece), 32'(board[expFrom].piece));
               phase = 1;
               i     = 0;
            end
         end
         if (phase == 1) begin
            if (gen_req) begin
               i++;
               gen_valid    = (i < 16) ? planMask[dd][i] : 1'b0;
               gen_position = planPos[dd][(i < 16) ? i : 0];
               gen_ack      = (planAck[dd] != 0) && (i == planAck[dd]);
            end else begin
               checkOutput("req length", 32'(i), 32'((planAck[dd] != 0) ? planAck[dd] : TIMEOUT));
               checkOutput("gen_from stable", 32'(gen_from), 32'(expFrom));
               holdLeft = (planAck[dd] != 0) ? planHold[dd] : 0;
               phase    = 2;
               d++;
            end
         end
         if (phase == 2) begin
            gen_valid    = 1'($urandom_range(0, 1));
            gen_position = 6'($urandom);
            if (holdLeft > 0) begin
               gen_ack = 1'b1;
               holdLeft--;
            end else begin
               gen_ack = 1'b0;
               phase   = 0;
            end
         end
         if (done) begin
            doneAt = n;
            checkOutput("busy at done", 32'(busy), 32'd0);
         end else if (!busy) begin
            busyBad++;
         end
      end
      checkOutput("done latency", 32'(doneAt), 32'(expLat));
      checkOutput("busy gaps", 32'(busyBad), 32'd0);
      checkOutput("dispatch count", 32'(d), 32'(expDisp.size()));
      checkOutput("moves left", 32'(expMoves.size()), 32'd0);
      checkOutput("final count", 32'(move_count), 32'(expCount));
      checkOutput("error flag", 32'(error), 32'(expErr));
      gen_valid = 1'b0;
      gen_ack   = 1'b0;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("done one cycle", 32'(done), 32'd0);
      checkOutput("start in done ignored", 32'(busy), 32'd0);
      checkOutput("count held", 32'(move_count), 32'(expCount));
      checkOutput("error held", 32'(error), 32'(expErr));
      if (doneAt < 0) begin
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
      end
   endtask

   // Directed passes followed by randomized boards
   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      side         = WHITE;
      gen_ack      = 1'b0;
      gen_valid    = 1'b0;
      gen_position = 6'd0;
      clearBoard();
      repeat (3) @(negedge clk);
      checkOutput("reset busy/done/error", 32'({busy, done, error}), 32'd0);
      checkOutput("reset move_count", 32'(move_count), 32'd0);
      checkOutput("reset move_valid", 32'(move_valid), 32'd0);
      checkOutput("reset gen_req", 32'(gen_req), 32'd0);
      checkOutput("reset move/gen fields", 32'({move_from, move_to, gen_from, gen_piece}), 32'd0);
      reset = 1'b0;

      $display("[TB] empty board");
      applyStimulus(WHITE, -1);

      $display("[TB] white king on 4");
      clearBoard();
      board[4].piece = KING;
      planAck[0] = 4; planHold[0] = 1; planMask[0] = 16'b1110;
      planPos[0][1] = 6'd3; planPos[0][2] = 6'd5; planPos[0][3] = 6'd12;
      applyStimulus(WHITE, -1);

      $display("[TB] side selection and valid with ack");
      clearBoard();
      board[0].color  = BLACK;  board[0].piece  = ROOK;
      board[63].color = BLACK;  board[63].piece = QUEEN;
      board[10].piece = KING;
      planAck[0] = 2; planMask[0] = 16'b0100; planPos[0][2] = 6'd20;
      applyStimulus(WHITE, -1);
      planAck[0] = 1; planMask[0] = 16'b0000;
      planAck[1] = 3; planHold[1] = 2; planMask[1] = 16'b1010;
      applyStimulus(BLACK, -1);

      $display("[TB] generator timeout");
      clearBoard();
      board[30].piece = KNIGHT;
      board[40].piece = PAWN;
      planAck[0] = 0; planMask[0] = 16'h01FE;
      planAck[1] = 2; planMask[1] = 16'b0010;
      applyStimulus(WHITE, -1);
      planAck[0] = 1; planMask[0] = 16'b0010;
      applyStimulus(WHITE, -1);

      $display("[TB] reset during request");
      clearBoard();
      board[5].piece = BISHOP;
      board[9].piece = ROOK;
      planAck[0] = 3; planMask[0] = 16'b0110;
      planAck[1] = 5; planMask[1] = 16'b0010;
      applyStimulus(WHITE, 1);
      applyStimulus(WHITE, -1);

      $display("[TB] move count saturation");
      clearBoard();
      for (int s = 0; s < 40; s++) begin
         board[s].piece = piece_t'(3'((s % 6) + 1));
         planAck[s]  = TIMEOUT;
         planMask[s] = 16'h01FE;
      end
      applyStimulus(WHITE, -1);

      $display("[TB] random boards");
      for (int r = 0; r < 6; r++) begin
         clearBoard();
         for (int s = 0; s < 64; s++) begin
            if ($urandom_range(0, 2) == 0) begin
               board[s].color = color_t'($urandom_range(0, 1));
               board[s].piece = piece_t'(3'($urandom_range(1, 6)));
            end
         end
         for (int d = 0; d < 64; d++) randPlan(d);
         applyStimulus(color_t'($urandom_range(0, 1)), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
